seq_alu: RTL

- Parametrised successor to the 16-bit combinational ALU in the CPU datapath.
- Registered single-cycle logic/arithmetic ops plus iterative multi-cycle unsigned multiply and divide.
- Valid/ready handshake on both sides so the control unit can stall on long ops.
- Sits between the register-file read ports and the writeback mux.

---
 rtl/seq_alu_pkg.sv | 28 ++
 rtl/seq_alu_muldiv.sv | 71 +++++++
 rtl/seq_alu.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM encoding and latency constants for seq_alu.
// SEQ_ALU_SIGNED_EN enables the signed op codes OP_MULS / OP_DIVS.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_LSR  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_MULS = 4'd10;
    localparam logic [3:0] OP_DIVS = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int LAT_SINGLE    = 1;
    localparam int LAT_ITER      = DEFAULT_WIDTH + 1;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle.
// done flags the final iteration; lo/hi carry that iteration's result combinationally.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [CNT_W-1:0] cnt;
    logic             div_q;
    logic [WIDTH-1:0] acc, q, m;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] sub_diff;
    logic [WIDTH-1:0] acc_nx, q_nx;

    // Multiply: {acc,q} shifts right, q holds the remaining multiplier bits.
    // Divide: {acc,q} shifts left, q collects quotient bits, acc is the partial remainder.
    always_comb begin
        add_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        shifted  = {acc, q[WIDTH-1]};
        sub_diff = {1'b0, shifted} - {2'b00, m};
        acc_nx   = add_sum[WIDTH:1];
        q_nx     = {add_sum[0], q[WIDTH-1:1]};
        if (div_q) begin
            if (sub_diff[WIDTH+1]) begin
                acc_nx = shifted[WIDTH-1:0];
                q_nx   = {q[WIDTH-2:0], 1'b0};
            end else begin
                acc_nx = sub_diff[WIDTH-1:0];
                q_nx   = {q[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= 1'b0;
            acc   <= '0;
            q     <= '0;
            m     <= '0;
        end else if (start) begin
            cnt   <= CNT_W'(WIDTH);
            div_q <= is_div;
            acc   <= '0;
            q     <= a;
            m     <= b;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            acc <= acc_nx;
            q   <= q_nx;
        end
    end

    assign done = (cnt == CNT_W'(1));
    assign lo   = q_nx;
    assign hi   = acc_nx;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: registered single-cycle ops plus iterative MULU/DIVU behind valid/ready.
// Defining SEQ_ALU_SIGNED_EN adds MULS/DIVS via sign correction around the unsigned engine.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             div_zero
);

    // Handshake: an op is taken on a cycle with in_valid && in_ready; a result
    // stays on the outputs while out_valid && !out_ready and retires on out_ready.
    state_t           state;
    logic             accept, is_iter, is_div_op, div_by_zero, eng_start, eng_done;
    logic             mul_q;
    logic [WIDTH-1:0] eng_a, eng_b, eng_lo, eng_hi;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        case (op)
            OP_SUB: begin
                sc_res   = a - b;
                sc_carry = (a < b);
            end
            OP_LSR: begin
                sc_res   = a >> 1;
                sc_carry = a[0];
            end
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_NOT:  sc_res = ~a;
            OP_XOR:  sc_res = a ^ b;
            default: {sc_carry, sc_res} = {1'b0, a} + {1'b0, b};
        endcase
    end

`ifdef SEQ_ALU_SIGNED_EN
    logic                 is_signed_op, sign_a, sign_b, is_ovf;
    logic                 signed_q, fix_q, neg_lo_q, neg_hi_q, ovf_q;
    logic [2*WIDTH-1:0]   prod_mag, prod_fix;
    logic [WIDTH-1:0]     fix_lo, fix_hi;
    logic                 fix_carry;

    assign is_signed_op = (op == OP_MULS) || (op == OP_DIVS);
    assign sign_a       = is_signed_op && a[WIDTH-1];
    assign sign_b       = is_signed_op && b[WIDTH-1];
    assign is_ovf       = (op == OP_DIVS) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign is_iter      = (op == OP_MULU) || (op == OP_DIVU) || is_signed_op;
    assign is_div_op    = (op == OP_DIVU) || (op == OP_DIVS);
    assign eng_a        = sign_a ? -a : a;
    assign eng_b        = sign_b ? -b : b;

    // Post-correction works on the magnitudes already parked in the result registers.
    assign prod_mag = {result_hi, result};
    assign prod_fix = neg_lo_q ? -prod_mag : prod_mag;

    always_comb begin
        fix_lo    = neg_lo_q ? -result : result;
        fix_hi    = neg_hi_q ? -result_hi : result_hi;
        fix_carry = ovf_q;
        if (mul_q) begin
            fix_lo    = prod_fix[WIDTH-1:0];
            fix_hi    = prod_fix[2*WIDTH-1:WIDTH];
            fix_carry = (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
        end
    end
`else
    assign is_iter   = (op == OP_MULU) || (op == OP_DIVU);
    assign is_div_op = (op == OP_DIVU);
    assign eng_a     = a;
    assign eng_b     = b;
`endif

    assign div_by_zero = is_div_op && (b == '0);
    assign eng_start   = accept && is_iter && !div_by_zero;

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (eng_start),
        .is_div (is_div_op),
        .a      (eng_a),
        .b      (eng_b),
        .done   (eng_done),
        .lo     (eng_lo),
        .hi     (eng_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            div_zero  <= 1'b0;
            mul_q     <= 1'b0;
`ifdef SEQ_ALU_SIGNED_EN
            signed_q  <= 1'b0;
            fix_q     <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    div_zero <= 1'b0;
                    mul_q    <= !is_div_op;
`ifdef SEQ_ALU_SIGNED_EN
                    signed_q <= is_signed_op;
                    neg_lo_q <= sign_a ^ sign_b;
                    neg_hi_q <= sign_a;
                    ovf_q    <= is_ovf;
`endif
                    if (div_by_zero) begin
                        result    <= '1;
                        result_hi <= a;
                        carry     <= 1'b0;
                        zero      <= 1'b0;
                        div_zero  <= 1'b1;
                        state     <= ST_DONE;
                    end else if (is_iter) begin
                        state <= ST_BUSY;
                    end else begin
                        result    <= sc_res;
                        result_hi <= '0;
                        carry     <= sc_carry;
                        zero      <= (sc_res == '0);
                        state     <= ST_DONE;
                    end
                end
                ST_BUSY: begin
                    if (eng_done) begin
                        result    <= eng_lo;
                        result_hi <= eng_hi;
                        carry     <= mul_q && (eng_hi != '0);
                        zero      <= (eng_lo == '0);
`ifdef SEQ_ALU_SIGNED_EN
                        if (signed_q) fix_q <= 1'b1;
                        else          state <= ST_DONE;
                    end else if (fix_q) begin
                        fix_q     <= 1'b0;
                        result    <= fix_lo;
                        result_hi <= fix_hi;
                        carry     <= fix_carry;
                        zero      <= (fix_lo == '0);
                        state     <= ST_DONE;
`else
                        state <= ST_DONE;
`endif
                    end
                end
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
